// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake and FIFO-core write bus for fifo_wr_arbiter.
// master is the arbiter side, slave is the requester/FIFO-core side.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH         = 8,
    parameter int POINTER_WIDTH = 4
);
    logic [3:0]           req_valid;
    logic [4*WIDTH-1:0]   req_data;
    logic [3:0]           req_last;
    logic [3:0]           req_ready;
    logic                 full;
    logic [POINTER_WIDTH:0] count;
    logic                 wr_en;
    logic [WIDTH-1:0]     fifo_input_data;
    logic [1:0]           grant_id;
    logic                 busy;

    modport master (
        input  req_valid, req_data, req_last, full, count,
        output req_ready, wr_en, fifo_input_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, full, count,
        input  req_ready, wr_en, fifo_input_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: four-requester burst arbiter feeding a FIFO core write port.
// Define FIFO_WR_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fifo_wr_arbiter #(
    parameter int WIDTH         = 8,
    parameter int POINTER_WIDTH = 4,
    parameter int BURST_MAX     = 4
) (
    input  logic clk,
    input  logic reset,
    fifo_wr_arbiter_if.master bus
);
    localparam int DEPTH = 2 ** POINTER_WIDTH;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state, state_nx;
    logic [1:0]             winner;
    logic [3:0]             beat_cnt;
    logic [POINTER_WIDTH+1:0] level;
    logic                   space, xfer, done;
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
    logic [1:0]             rr_ptr;
`endif

    always_comb begin
`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
        winner = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (bus.req_valid[k]) winner = 2'(k);
`else
        // descending scan so the first valid index at or after rr_ptr wins
        winner = rr_ptr;
        for (int k = 3; k >= 0; k--)
            if (bus.req_valid[rr_ptr + 2'(k)]) winner = rr_ptr + 2'(k);
`endif
        // the in-flight write counts against occupancy so the core never overflows
        level         = {1'b0, bus.count} + (POINTER_WIDTH+2)'(bus.wr_en);
        space         = (level < (POINTER_WIDTH+2)'(DEPTH)) && !bus.full;
        bus.busy      = state == BURST;
        bus.req_ready = (!reset && state == BURST && space) ? 4'b0001 << bus.grant_id : 4'b0000;
        xfer          = !reset && state == BURST && space && bus.req_valid[bus.grant_id];
        done          = state == BURST && (!bus.req_valid[bus.grant_id] ||
                        (xfer && (bus.req_last[bus.grant_id] || beat_cnt + 4'd1 == 4'(BURST_MAX))));
        state_nx      = state == IDLE ? (|bus.req_valid ? BURST : IDLE) : (done ? IDLE : BURST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            bus.wr_en           <= 1'b0;
            bus.fifo_input_data <= '0;
            bus.grant_id        <= 2'd0;
            beat_cnt            <= 4'd0;
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
            rr_ptr              <= 2'd0;
`endif
        end else begin
            state     <= state_nx;
            bus.wr_en <= xfer;
            if (xfer) bus.fifo_input_data <= bus.req_data[bus.grant_id*WIDTH +: WIDTH];
            if (state == IDLE && |bus.req_valid) begin
                bus.grant_id <= winner;
                beat_cnt     <= 4'd0;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
            if (done) rr_ptr <= bus.grant_id + 2'd1;
`endif
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter with queue-backed requesters.
// Writes and grants are logged and compared against hand-computed sequences.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.WIDTH(8), .POINTER_WIDTH(4)) bus ();
    fifo_wr_arbiter #(.WIDTH(8), .POINTER_WIDTH(4), .BURST_MAX(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0, bad = 0, cyc = 0;
    logic [8:0] qm [4][16];
    int hd [4];
    int tl [4];
    logic [3:0] fire;
    logic busy_q = 1'b0;
    logic [7:0] wr_log [$];
    int wr_cyc [$];
    int gnt_log [$];
    int exp_g [6];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]       = hd[i] < tl[i];
            bus.req_data[i*8 +: 8] = hd[i] < tl[i] ? qm[i][hd[i]][7:0] : 8'h00;
            bus.req_last[i]        = hd[i] < tl[i] ? qm[i][hd[i]][8] : 1'b0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        qm[r][tl[r]] = {l, d};
        tl[r]++;
        drive();
    endtask

    // one clock: accept per handshake seen before the edge, then log at the falling edge
    task automatic step();
        #1;
        fire = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (fire[i]) hd[i]++;
        drive();
        @(negedge clk);
        cyc++;
        if (bus.wr_en) begin
            wr_log.push_back(bus.fifo_input_data);
            wr_cyc.push_back(cyc);
        end
        if (bus.busy && !busy_q) gnt_log.push_back(int'(bus.grant_id));
        busy_q = bus.busy;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        gnt_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.full = 1'b0;
        bus.count = '0;
        for (int i = 0; i < 4; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        drive();
        run(2);
        reset = 1'b0;
        busy_q = 1'b0;
        clear_logs();
    endtask

    initial begin
        bus.full = 1'b0;
        bus.count = '0;
        for (int i = 0; i < 4; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        drive();
        @(negedge clk);
        run(2);
        push(0, 8'h5A, 1'b1);
        step();
        check("rst_ready", bus.req_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant_id, 0);
        check("rst_data", bus.fifo_input_data, 0);

        // single requester, three beats with last on the third
        do_reset();
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        run(8);
        check("single_n", wr_log.size(), 3);
        check("single_w0", wr_log[0], 8'h11);
        check("single_w1", wr_log[1], 8'h22);
        check("single_w2", wr_log[2], 8'h33);
        check("single_back2back", wr_cyc[2] - wr_cyc[0], 2);
        check("single_grants", gnt_log.size(), 1);
        check("single_gid", gnt_log[0], 1);
        check("single_idle", bus.busy, 0);

        // burst cap of 4 with six words and no last
        do_reset();
        for (int i = 0; i < 6; i++) push(0, 8'hA0 + 8'(i), 1'b0);
        run(14);
        check("cap_n", wr_log.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("cap_w%0d", i), wr_log[i], 8'hA0 + 8'(i));
        check("cap_first4", wr_cyc[3] - wr_cyc[0], 3);
        check("cap_rearb_gap", wr_cyc[4] - wr_cyc[3], 2);
        check("cap_grants", gnt_log.size(), 2);

        // arbitration order with single-beat bursts from 0, 2, 3
        do_reset();
        push(0, 8'h00, 1'b1); push(0, 8'h01, 1'b1);
        push(2, 8'h20, 1'b1); push(2, 8'h21, 1'b1);
        push(3, 8'h30, 1'b1); push(3, 8'h31, 1'b1);
        run(16);
`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
        exp_g = '{0, 0, 2, 2, 3, 3};
`else
        exp_g = '{0, 2, 3, 0, 2, 3};
`endif
        check("arb_grants", gnt_log.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("arb_g%0d", i), gnt_log[i], exp_g[i]);
        check("arb_writes", wr_log.size(), 6);

        // full boundary at count 15 of 16
        do_reset();
        bus.count = 5'd15;
        push(1, 8'hB0, 1'b0);
        push(1, 8'hB1, 1'b1);
        for (int i = 0; i < 10 && !bus.wr_en; i++) step();
        check("full_w0_en", bus.wr_en, 1);
        check("full_w0", bus.fifo_input_data, 8'hB0);
        check("full_ready0", bus.req_ready, 0);
        bus.full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("full_hold%0d", i), bus.wr_en, 0);
        end
        check("full_busy", bus.busy, 1);
        bus.full = 1'b0;
        bus.count = 5'd14;
        for (int i = 0; i < 5 && !bus.wr_en; i++) step();
        check("full_w1_en", bus.wr_en, 1);
        check("full_w1", bus.fifo_input_data, 8'hB1);

        // reset after beat 2 of a 4-beat burst
        do_reset();
        for (int i = 0; i < 4; i++) push(2, 8'hC0 + 8'(i), i == 3);
        for (int i = 0; i < 10 && wr_log.size() < 2; i++) step();
        check("mid_beats", wr_log.size(), 2);
        reset = 1'b1;
        #1;
        check("mid_ready_in_reset", bus.req_ready, 0);
        step();
        check("mid_wr_en", bus.wr_en, 0);
        check("mid_busy", bus.busy, 0);
        check("mid_grant", bus.grant_id, 0);
        reset = 1'b0;
        busy_q = 1'b0;
        clear_logs();
        push(0, 8'hD0, 1'b1);
        run(10);
        check("mid_restart_g0", gnt_log[0], 0);
        check("mid_restart_g1", gnt_log[1], 2);
        check("mid_restart_n", wr_log.size(), 3);
        check("mid_restart_w0", wr_log[0], 8'hD0);
        check("mid_restart_w1", wr_log[1], 8'hC2);
        check("mid_restart_w2", wr_log[2], 8'hC3);

        // owner drops valid after one beat
        do_reset();
        push(1, 8'hE0, 1'b0);
        push(2, 8'hE1, 1'b1);
        run(10);
        check("drop_grants", gnt_log.size(), 2);
        check("drop_g0", gnt_log[0], 1);
        check("drop_g1", gnt_log[1], 2);
        check("drop_w0", wr_log[0], 8'hE0);
        check("drop_w1", wr_log[1], 8'hE1);
        check("drop_idle", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter POINTER_WIDTH, default 4; FIFO depth DEPTH = 2**POINTER_WIDTH.
REQ-003 Parameter BURST_MAX, default 4, maximum beats per grant (range 1..15).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  4  per-requester word-valid, requester i on bit i.
REQ-007 req_data  input  4*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
REQ-008 req_last  input  4  per-requester end-of-burst marker, qualified by valid.
REQ-009 req_ready  output  4  per-requester accept, combinational.
REQ-010 full  input  1  FIFO core full flag.
REQ-011 count  input  POINTER_WIDTH+1  FIFO core occupancy.
REQ-012 wr_en  output  1  registered write strobe to the FIFO core.
REQ-013 fifo_input_data  output  WIDTH  registered write data to the FIFO core.
REQ-014 grant_id  output  2  index of the current owner; valid while busy is high.
REQ-015 busy  output  1  high in state BURST.

Function
REQ-016 The FSM SHALL have two states: IDLE and BURST.
REQ-017 In IDLE with any req_valid bit high, the arbiter SHALL latch the winner into grant_id and enter BURST on the next cycle.
REQ-018 With no req_valid bits high, the FSM SHALL remain in IDLE, and req_ready SHALL be 0.
REQ-019 Winner selection SHALL be round-robin: search starts at rr_ptr and wraps 3->0.
REQ-020 rr_ptr SHALL load grant_id+1 (mod 4) on every BURST->IDLE transition.
REQ-021 space SHALL be true when count + wr_en < DEPTH, computed at POINTER_WIDTH+2 bits, and full low.
REQ-022 req_ready[grant_id] SHALL equal (state==BURST && space); all other req_ready bits SHALL be 0.
REQ-023 A beat SHALL transfer when req_valid[grant_id] and req_ready[grant_id] are both high.
REQ-024 On a transfer, wr_en SHALL be 1 and fifo_input_data SHALL hold that word in the following cycle (1-cycle latency); otherwise wr_en SHALL be 0 and fifo_input_data SHALL hold its value.
REQ-025 A 4-bit beat counter SHALL clear on entry to BURST and increment per transfer.
REQ-026 BURST->IDLE SHALL occur when any of the following is true:
- a transfer with req_last high;
- a transfer that makes beat count equal BURST_MAX;
- req_valid[grant_id] is low.
REQ-027 While space is false in BURST, the FSM SHALL stay in BURST, the beat count SHALL hold, and no timeout applies.
REQ-028 An owner dropping valid while stalled on full SHALL release the grant per REQ-026.
REQ-029 A requester SHALL never overflow the core: at count==DEPTH-1 with wr_en high, req_ready SHALL be 0.

Reset
REQ-030 On reset, the arbiter SHALL set the following: state=IDLE, wr_en=0, fifo_input_data=0, grant_id=0, busy=0, rr_ptr=0, beat count=0.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no write issued in the following cycle.
REQ-032 While reset is high, req_ready SHALL be 0.

Configuration
REQ-033 With macro FIFO_WR_ARBITER_FIXED_PRIO_EN defined, winner selection SHALL be fixed priority, with lowest index winning, and rr_ptr SHALL be unused.
REQ-034 With FIFO_WR_ARBITER_FIXED_PRIO_EN undefined, selection SHALL be round-robin per REQ-019/REQ-020; ports SHALL be identical in both builds.

Verification
REQ-035 Single requester: req 1 streams 0x11,0x22,0x33 with last on 0x33, count=0; wr_en SHALL pulse 3 cycles with 0x11,0x22,0x33, then return to IDLE.
REQ-036 Burst cap: req 0 holds valid with 6 words and no last, BURST_MAX=4; exactly 4 words SHALL be written, a re-arbitration cycle SHALL follow, and the remaining 2 SHALL be written afterwards.
REQ-037 Round-robin: reqs 0,2,3 valid continuously, each sending single-beat bursts with last high; the grant order SHALL be 0,2,3,0,2; under FIFO_WR_ARBITER_FIXED_PRIO_EN it SHALL be 0,0,0,...
REQ-038 Full boundary: count=15, DEPTH=16, one transfer occurs; next cycle req_ready SHALL be 0; with full high, wr_en SHALL stay 0 until count drops to 14.
REQ-039 Reset mid-burst: assert reset after beat 2 of 4; next cycle wr_en=0, busy=0, grant_id=0; after release, arbitration SHALL restart from rr_ptr=0.
REQ-040 Valid drop: the owner deasserts valid after 1 beat; FSM SHALL return to IDLE and the next requester SHALL be granted.
